tape_controller: RTL and testbench

TAPE_CONTROLLER -- requirements
Module: tape_controller

---
 rtl/tape_controller.sv | 174 +++++++++++++++++
 tb/tb_tape_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tape_controller.sv
// tape_controller
// Sequencer for a simple tape machine: a data pointer walks a tape held in an
// external RAM, and a command stream moves the pointer, increments or
// decrements the current cell, or moves bytes between the current cell and
// the output/input byte streams. Reset sweeps the whole tape to zero before
// any command is accepted.
//
// Ports
//   i_clock                   single clock, all state changes on posedge
//   i_reset                   synchronous active-high reset
//   i_cmd_valid/i_cmd         command stream (0 PTR_INC, 1 PTR_DEC, 2 CELL_INC,
//   o_cmd_ready                3 CELL_DEC, 4 OUT, 5 IN, 6-7 NOP)
//   o_out_valid/o_out_data    output byte stream
//   i_out_ready
//   i_in_valid/i_in_data      input byte stream
//   o_in_ready
//   o_ram_addr/o_ram_data     tape RAM initiator: combinational read of
//   o_ram_we/i_ram_data        o_ram_addr, write when o_ram_we at the edge
//   o_ptr                     data pointer (always equal to o_ram_addr)
//   o_cell_zero               current cell reads zero
module tape_controller #(
  parameter int c_addr_width = 8,
  parameter int c_data_width = 8
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_cmd_valid,
  input  logic [2:0]              i_cmd,
  output logic                    o_cmd_ready,
  output logic                    o_out_valid,
  output logic [c_data_width-1:0] o_out_data,
  input  logic                    i_out_ready,
  input  logic                    i_in_valid,
  input  logic [c_data_width-1:0] i_in_data,
  output logic                    o_in_ready,
  output logic [c_addr_width-1:0] o_ram_addr,
  output logic [c_data_width-1:0] o_ram_data,
  output logic                    o_ram_we,
  input  logic [c_data_width-1:0] i_ram_data,
  output logic [c_addr_width-1:0] o_ptr,
  output logic                    o_cell_zero
);

  localparam logic [2:0] c_cmd_ptr_inc  = 3'd0;
  localparam logic [2:0] c_cmd_ptr_dec  = 3'd1;
  localparam logic [2:0] c_cmd_cell_inc = 3'd2;
  localparam logic [2:0] c_cmd_cell_dec = 3'd3;
  localparam logic [2:0] c_cmd_out      = 3'd4;
  localparam logic [2:0] c_cmd_in       = 3'd5;

  localparam logic [c_addr_width-1:0] c_ptr_one  = c_addr_width'(1);
  localparam logic [c_addr_width-1:0] c_ptr_zero = c_addr_width'(0);
  localparam logic [c_addr_width-1:0] c_ptr_last = {c_addr_width{1'b1}};
  localparam logic [c_data_width-1:0] c_data_one  = c_data_width'(1);
  localparam logic [c_data_width-1:0] c_data_zero = c_data_width'(0);

  typedef enum logic [2:0] {
    st_clear = 3'd0,
    st_idle  = 3'd1,
    st_exec  = 3'd2,
    st_out   = 3'd3,
    st_in    = 3'd4
  } state_t;

  state_t                  state_r, state_s;
  logic [c_addr_width-1:0] ptr_r, ptr_s;
  logic [2:0]              cmd_r, cmd_s;
  logic                    out_valid_r, out_valid_s;
  logic [c_data_width-1:0] out_data_r, out_data_s;
  logic                    ram_we_s;
  logic [c_data_width-1:0] ram_data_s;

  // State register; reset restarts the zeroing sweep from address 0.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r     <= st_clear;
      ptr_r       <= c_ptr_zero;
      cmd_r       <= 3'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= c_data_zero;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      cmd_r       <= cmd_s;
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
    end
  end

  // Next-state and RAM write control.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    cmd_s       = cmd_r;
    out_valid_s = out_valid_r;
    out_data_s  = out_data_r;
    ram_we_s    = 1'b0;
    ram_data_s  = c_data_zero;
    case (state_r)
      st_clear: begin
        // Pointer wraps naturally back to 0 after the last cell is written.
        ram_we_s = 1'b1;
        ptr_s    = ptr_r + c_ptr_one;
        if (ptr_r == c_ptr_last) begin
          state_s = st_idle;
        end else begin
          state_s = st_clear;
        end
      end
      st_idle: begin
        if (i_cmd_valid) begin
          cmd_s   = i_cmd;
          state_s = st_exec;
        end else begin
          state_s = st_idle;
        end
      end
      st_exec: begin
        state_s = st_idle;
        case (cmd_r)
          c_cmd_ptr_inc:  ptr_s = ptr_r + c_ptr_one;
          c_cmd_ptr_dec:  ptr_s = ptr_r - c_ptr_one;
          c_cmd_cell_inc: begin
            ram_we_s   = 1'b1;
            ram_data_s = i_ram_data + c_data_one;
          end
          c_cmd_cell_dec: begin
            ram_we_s   = 1'b1;
            ram_data_s = i_ram_data - c_data_one;
          end
          c_cmd_out: begin
            out_data_s  = i_ram_data;
            out_valid_s = 1'b1;
            state_s     = st_out;
          end
          c_cmd_in:       state_s = st_in;
          default:        state_s = st_idle;
        endcase
      end
      st_out: begin
        if (i_out_ready) begin
          out_valid_s = 1'b0;
          state_s     = st_idle;
        end else begin
          state_s = st_out;
        end
      end
      st_in: begin
        if (i_in_valid) begin
          ram_we_s   = 1'b1;
          ram_data_s = i_in_data;
          state_s    = st_idle;
        end else begin
          state_s = st_in;
        end
      end
      default: begin
        state_s = st_clear;
        ptr_s   = c_ptr_zero;
      end
    endcase
  end

  assign o_cmd_ready = (state_r == st_idle);
  assign o_in_ready  = (state_r == st_in);
  assign o_out_valid = out_valid_r;
  assign o_out_data  = out_data_r;
  assign o_ptr       = ptr_r;
  assign o_ram_addr  = ptr_r;
  assign o_ram_we    = ram_we_s;
  assign o_ram_data  = ram_data_s;
  assign o_cell_zero = (i_ram_data == c_data_zero);

endmodule

// File: tb/tb_tape_controller.sv
// Bench for tape_controller (4-bit address, 8-bit cells). Owns the tape RAM,
// keeps a behavioural model of the tape and pointer, and checks directed
// scenarios plus a randomized command stream against it.
module tb_tape_controller;

  localparam int aw = 4;
  localparam int dw = 8;
  localparam int tape_len = 16;

  logic          i_clock;
  logic          i_reset;
  logic          i_cmd_valid;
  logic [2:0]    i_cmd;
  logic          o_cmd_ready;
  logic          o_out_valid;
  logic [dw-1:0] o_out_data;
  logic          i_out_ready;
  logic          i_in_valid;
  logic [dw-1:0] i_in_data;
  logic          o_in_ready;
  logic [aw-1:0] o_ram_addr;
  logic [dw-1:0] o_ram_data;
  logic          o_ram_we;
  logic [dw-1:0] i_ram_data;
  logic [aw-1:0] o_ptr;
  logic          o_cell_zero;

  tape_controller #(.c_addr_width(aw), .c_data_width(dw)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd), .o_cmd_ready(o_cmd_ready),
    .o_out_valid(o_out_valid), .o_out_data(o_out_data), .i_out_ready(i_out_ready),
    .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
    .o_ram_addr(o_ram_addr), .o_ram_data(o_ram_data), .o_ram_we(o_ram_we),
    .i_ram_data(i_ram_data), .o_ptr(o_ptr), .o_cell_zero(o_cell_zero)
  );

  // Tape RAM owned by the bench.
  logic [dw-1:0] ram [tape_len];
  always @(posedge i_clock) begin
    if (o_ram_we) ram[o_ram_addr] <= o_ram_data;
  end
  assign i_ram_data = ram[o_ram_addr];

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Reference model.
  int model_tape [tape_len];
  int model_ptr;

  int n_vec;
  int n_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    @(negedge i_clock);
  endtask

  task automatic model_reset();
    for (int i = 0; i < tape_len; i++) model_tape[i] = 0;
    model_ptr = 0;
  endtask

  // Entered at the negedge after a reset edge with i_reset still high.
  task automatic clear_sweep();
    int n;
    int nz;
    n = 0;
    i_reset = 1'b0;
    for (int c = 0; c < 40 && !o_cmd_ready; c++) begin
      if (o_ram_we) begin
        check_val("clr_addr", 32'(o_ram_addr), 32'(n % tape_len));
        check_val("clr_data", 32'(o_ram_data), 32'd0);
        n++;
      end
      check_val("clr_outv", 32'(o_out_valid), 32'd0);
      check_val("clr_inrdy", 32'(o_in_ready), 32'd0);
      tick();
    end
    check_val("clr_count", 32'(n), 32'd16);
    check_val("clr_ready", 32'(o_cmd_ready), 32'd1);
    check_val("clr_ptr", 32'(o_ptr), 32'd0);
    check_val("clr_zero", 32'(o_cell_zero), 32'd1);
    nz = 0;
    for (int i = 0; i < tape_len; i++) if (ram[i] != '0) nz++;
    check_val("clr_tape", 32'(nz), 32'd0);
    model_reset();
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_rdy"}, 32'(o_cmd_ready), 32'd1);
    check_val({tag, "_ptr"}, 32'(o_ptr), 32'(model_ptr));
    check_val({tag, "_addr"}, 32'(o_ram_addr), 32'(model_ptr));
    check_val({tag, "_zero"}, 32'(o_cell_zero), 32'(model_tape[model_ptr] == 0));
    check_val({tag, "_we"}, 32'(o_ram_we), 32'd0);
    check_val({tag, "_outv"}, 32'(o_out_valid), 32'd0);
  endtask

  // Issue one command from IDLE and follow it back to IDLE.
  task automatic do_cmd(input int cmd, input int in_delay, input int out_delay, input logic [dw-1:0] in_byte);
    int exp_out;
    check_val("accept_rdy", 32'(o_cmd_ready), 32'd1);
    i_cmd_valid = 1'b1;
    i_cmd = 3'(cmd);
    tick();
    i_cmd_valid = 1'b0;
    i_cmd = 3'($urandom_range(0, 7));
    check_val("exec_rdy", 32'(o_cmd_ready), 32'd0);
    exp_out = model_tape[model_ptr];
    tick();
    case (cmd)
      0: model_ptr = (model_ptr + 1) % tape_len;
      1: model_ptr = (model_ptr + tape_len - 1) % tape_len;
      2: model_tape[model_ptr] = (model_tape[model_ptr] + 1) % 256;
      3: model_tape[model_ptr] = (model_tape[model_ptr] + 255) % 256;
      4: begin
        for (int k = 0; k < out_delay; k++) begin
          i_out_ready = 1'b0;
          check_val("out_hold_v", 32'(o_out_valid), 32'd1);
          check_val("out_hold_d", 32'(o_out_data), 32'(exp_out));
          check_val("out_hold_rdy", 32'(o_cmd_ready), 32'd0);
          tick();
        end
        i_out_ready = 1'b1;
        check_val("out_v", 32'(o_out_valid), 32'd1);
        check_val("out_d", 32'(o_out_data), 32'(exp_out));
        tick();
        i_out_ready = 1'b0;
      end
      5: begin
        for (int k = 0; k < in_delay; k++) begin
          i_in_valid = 1'b0;
          check_val("in_wait_rdy", 32'(o_in_ready), 32'd1);
          check_val("in_wait_we", 32'(o_ram_we), 32'd0);
          tick();
        end
        i_in_valid = 1'b1;
        i_in_data = in_byte;
        check_val("in_rdy", 32'(o_in_ready), 32'd1);
        tick();
        i_in_valid = 1'b0;
        i_in_data = dw'($urandom);
        model_tape[model_ptr] = int'(in_byte);
      end
      default: ;
    endcase
    check_val("post_inrdy", 32'(o_in_ready), 32'd0);
    check_idle("idle");
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    i_reset = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd = 3'd0;
    i_out_ready = 1'b0;
    i_in_valid = 1'b0;
    i_in_data = '0;
    for (int i = 0; i < tape_len; i++) ram[i] = dw'($urandom_range(1, 255));
    model_reset();

    // Reset state then full sweep.
    tick();
    check_val("rst_rdy", 32'(o_cmd_ready), 32'd0);
    check_val("rst_outv", 32'(o_out_valid), 32'd0);
    check_val("rst_outd", 32'(o_out_data), 32'd0);
    check_val("rst_inrdy", 32'(o_in_ready), 32'd0);
    check_val("rst_ptr", 32'(o_ptr), 32'd0);
    clear_sweep();

    // CELL_DEC wraps 0 -> 0xFF, OUT shows it for one cycle, CELL_INC back to 0.
    do_cmd(3, 0, 0, 8'h00);
    do_cmd(4, 0, 0, 8'h00);
    do_cmd(2, 0, 0, 8'h00);
    check_val("inc_back_zero", 32'(o_cell_zero), 32'd1);

    // Pointer wraps both ways; cell 15 untouched.
    do_cmd(1, 0, 0, 8'h00);
    check_val("ptr_wrap_dn", 32'(o_ptr), 32'd15);
    check_val("cell15_zero", 32'(o_cell_zero), 32'd1);
    do_cmd(0, 0, 0, 8'h00);
    check_val("ptr_wrap_up", 32'(o_ptr), 32'd0);

    // IN after 5 idle cycles, OUT with 3 stall cycles.
    do_cmd(5, 5, 0, 8'h41);
    do_cmd(4, 0, 3, 8'h00);

    // Randomized command stream.
    for (int t = 0; t < 300; t++) begin
      int c;
      logic [dw-1:0] b;
      c = int'($urandom_range(0, 7));
      b = ($urandom_range(0, 3) == 0) ? dw'(0) : dw'($urandom);
      do_cmd(c, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), b);
    end

    // Reset mid-CLEAR restarts the sweep.
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    i_reset = 1'b1;
    tick();
    clear_sweep();

    // Reset while OUT is pending with a nonzero cell.
    do_cmd(5, 1, 0, 8'h5A);
    i_cmd_valid = 1'b1;
    i_cmd = 3'd4;
    tick();
    i_cmd_valid = 1'b0;
    tick();
    check_val("pre_rst_outv", 32'(o_out_valid), 32'd1);
    check_val("pre_rst_outd", 32'(o_out_data), 32'h5A);
    i_reset = 1'b1;
    tick();
    check_val("rst_out_v", 32'(o_out_valid), 32'd0);
    check_val("rst_out_d", 32'(o_out_data), 32'd0);
    check_val("rst_out_rdy", 32'(o_cmd_ready), 32'd0);
    clear_sweep();
    do_cmd(4, 0, 1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
